cascade_counter_n: RTL and testbench



---
 rtl/counters_pkg.sv | 14 +
 rtl/addsub_n.sv | 30 +++
 rtl/cascade_counter_n.sv | 93 +++++++++
 tb/tb_cascade_counter_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/counters_pkg.sv
// Shared types and limits for the counters block: terminal-count policy
// encoding and the supported counter width range.
package counters_pkg;

  typedef enum logic [1:0] {
    CNT_WRAP   = 2'd0,
    CNT_SAT    = 2'd1,
    CNT_RELOAD = 2'd2
  } cnt_mode_t;

  localparam int CNT_WIDTH_MIN = 2;
  localparam int CNT_WIDTH_MAX = 32;

endpackage

// File: rtl/addsub_n.sv
// Ripple add/subtract of the constant 1 gated by a carry-in. Up counts use
// the carry chain, down counts the borrow chain; co_o is the chain output.
module addsub_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             dn_i,
  input  logic             ci_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] propN;
  logic [WIDTH-1:0] carryN;

  assign carry[0] = ci_i;

  // Each cell propagates when its bit is 1 going up or 0 going down, so the
  // chain reaches the top only at all-ones (up) or zero (down).
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign propN[i]     = ~(a_i[i] ^ dn_i);
    assign carryN[i]    = ~carry[i];
    assign carry[i + 1] = ~(propN[i] | carryN[i]);
    assign sum_o[i]     = a_i[i] ^ carry[i];
  end

  assign co_o = carry[WIDTH];

endmodule

// File: rtl/cascade_counter_n.sv
// Loadable, cascadable up/down counter with a reload register and a
// selectable terminal-count policy (wrap, saturate or auto-reload).
module cascade_counter_n
  import counters_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter cnt_mode_t        MODE       = CNT_WRAP,
  parameter logic [WIDTH-1:0] RST_RELOAD = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ld_i,
  input  logic             rld_wr_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             en_i,
  input  logic             cin_i,
  input  logic             dn_i,
  output logic [WIDTH-1:0] q_o,
  output logic             cout_o,
  output logic             tc_o,
  output logic [WIDTH-1:0] rld_q_o
);

  if (WIDTH < CNT_WIDTH_MIN || WIDTH > CNT_WIDTH_MAX) begin : g_bad_width
    $error("cascade_counter_n: WIDTH out of supported range");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] stepSum;
  logic             term;
  logic             step;

  // The chain always runs with carry-in 1 so its carry out doubles as the
  // terminal detector regardless of whether a step actually happens.
  addsub_n #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a_i  (count_q),
    .dn_i (dn_i),
    .ci_i (1'b1),
    .sum_o(stepSum),
    .co_o (term)
  );

  assign step = en_i & cin_i & ~ld_i;

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (ld_i) begin
      count_d = din_i;
    end else if (step) begin
      tc_d = term;
      if (!term) begin
        count_d = stepSum;
      end else begin
        // Wrap mode takes the chain result, which is already 0 / all-ones.
        case (MODE)
          CNT_WRAP:   count_d = stepSum;
          CNT_SAT:    count_d = count_q;
          CNT_RELOAD: count_d = reload_q;
          default:    count_d = stepSum;
        endcase
      end
    end

    if (rld_wr_i) begin
      reload_d = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q  <= '0;
      reload_q <= RST_RELOAD;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q_o     = count_q;
  assign rld_q_o = reload_q;
  assign tc_o    = tc_q;
  assign cout_o  = step & term & ~reset_i;

endmodule

// File: tb/tb_cascade_counter_n.sv
// Directed bench for cascade_counter_n: wrap, saturate, reload, load priority,
// two-stage cascade and reset behaviour on 4-bit instances.
module tb_cascade_counter_n;
  import counters_pkg::*;

  logic clk;
  logic reset;
  logic ld;
  logic rldWr;
  logic [3:0] din;
  logic en;
  logic cin;
  logic dn;

  logic [3:0] wrapQ, wrapRld, satQ, satRld, relQ, relRld;
  logic wrapCout, wrapTc, satCout, satTc, relCout, relTc;

  logic [3:0] cDinLo, cDinHi;
  logic [3:0] loQ, hiQ, loRld, hiRld;
  logic loCout, hiCout, loTc, hiTc;

  int checkCount = 0;
  int passCount  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cascade_counter_n #(.WIDTH(4), .MODE(CNT_WRAP), .RST_RELOAD(4'h0)) u_wrap (
    .clk_i(clk), .reset_i(reset), .ld_i(ld), .rld_wr_i(rldWr), .din_i(din),
    .en_i(en), .cin_i(cin), .dn_i(dn), .q_o(wrapQ), .cout_o(wrapCout),
    .tc_o(wrapTc), .rld_q_o(wrapRld)
  );

  cascade_counter_n #(.WIDTH(4), .MODE(CNT_SAT), .RST_RELOAD(4'h0)) u_sat (
    .clk_i(clk), .reset_i(reset), .ld_i(ld), .rld_wr_i(rldWr), .din_i(din),
    .en_i(en), .cin_i(cin), .dn_i(dn), .q_o(satQ), .cout_o(satCout),
    .tc_o(satTc), .rld_q_o(satRld)
  );

  cascade_counter_n #(.WIDTH(4), .MODE(CNT_RELOAD), .RST_RELOAD(4'hA)) u_rel (
    .clk_i(clk), .reset_i(reset), .ld_i(ld), .rld_wr_i(rldWr), .din_i(din),
    .en_i(en), .cin_i(cin), .dn_i(dn), .q_o(relQ), .cout_o(relCout),
    .tc_o(relTc), .rld_q_o(relRld)
  );

  cascade_counter_n #(.WIDTH(4), .MODE(CNT_WRAP), .RST_RELOAD(4'h0)) u_lo (
    .clk_i(clk), .reset_i(reset), .ld_i(ld), .rld_wr_i(1'b0), .din_i(cDinLo),
    .en_i(en), .cin_i(cin), .dn_i(dn), .q_o(loQ), .cout_o(loCout),
    .tc_o(loTc), .rld_q_o(loRld)
  );

  cascade_counter_n #(.WIDTH(4), .MODE(CNT_WRAP), .RST_RELOAD(4'h0)) u_hi (
    .clk_i(clk), .reset_i(reset), .ld_i(ld), .rld_wr_i(1'b0), .din_i(cDinHi),
    .en_i(en), .cin_i(loCout), .dn_i(dn), .q_o(hiQ), .cout_o(hiCout),
    .tc_o(hiTc), .rld_q_o(hiRld)
  );

  // One comparison: count it, and report any difference with both values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    else
      passCount++;
  endtask

  // Advance one edge and settle just after it, where inputs are also driven.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] expQ;
  logic       prevTerm;
  logic [3:0] satSeq [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
  logic       satTcSeq [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset = 1'b1; ld = 1'b0; rldWr = 1'b0; din = 4'h0;
    en = 1'b0; cin = 1'b1; dn = 1'b0; cDinLo = 4'h0; cDinHi = 4'h0;

    // Reset state
    applyStimulus();
    checkOutput("rst_q", {28'd0, wrapQ}, 32'd0);
    checkOutput("rst_tc", {31'd0, wrapTc}, 32'd0);
    checkOutput("rst_rld", {28'd0, relRld}, 32'hA);
    checkOutput("rst_cout", {31'd0, wrapCout}, 32'd0);
    reset = 1'b0;

    // Wrap up-count over 17 steps
    en = 1'b1; dn = 1'b0;
    expQ = 4'd0; prevTerm = 1'b0;
    #1;
    for (int i = 0; i < 17; i++) begin
      checkOutput("wrap_q", {28'd0, wrapQ}, {28'd0, expQ});
      checkOutput("wrap_cout", {31'd0, wrapCout}, {31'd0, (expQ == 4'd15)});
      checkOutput("wrap_tc", {31'd0, wrapTc}, {31'd0, prevTerm});
      prevTerm = (expQ == 4'd15);
      expQ = expQ + 4'd1;
      applyStimulus();
    end
    checkOutput("wrap_q_end", {28'd0, wrapQ}, 32'd1);
    checkOutput("wrap_tc_end", {31'd0, wrapTc}, 32'd0);

    // Saturating down-count from 2
    en = 1'b0; ld = 1'b1; din = 4'd2;
    applyStimulus();
    ld = 1'b0; en = 1'b1; dn = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("sat_q", {28'd0, satQ}, {28'd0, satSeq[k]});
      checkOutput("sat_tc", {31'd0, satTc}, {31'd0, satTcSeq[k]});
      applyStimulus();
    end
    checkOutput("sat_hold", {28'd0, satQ}, 32'd0);

    // Auto-reload with a reload write landing on the terminal step
    en = 1'b0; rldWr = 1'b1; din = 4'd9;
    applyStimulus();
    rldWr = 1'b0; ld = 1'b1; din = 4'd1;
    applyStimulus();
    ld = 1'b0; en = 1'b1; dn = 1'b1;
    checkOutput("rel_q_ld", {28'd0, relQ}, 32'd1);
    checkOutput("rel_rld", {28'd0, relRld}, 32'd9);
    checkOutput("rel_tc_ld", {31'd0, relTc}, 32'd0);
    applyStimulus();
    checkOutput("rel_q0", {28'd0, relQ}, 32'd0);
    rldWr = 1'b1; din = 4'd5;
    #1;
    checkOutput("rel_cout", {31'd0, relCout}, 32'd1);
    applyStimulus();
    rldWr = 1'b0;
    checkOutput("rel_q_old", {28'd0, relQ}, 32'd9);
    checkOutput("rel_rld_new", {28'd0, relRld}, 32'd5);
    checkOutput("rel_tc", {31'd0, relTc}, 32'd1);
    applyStimulus();
    checkOutput("rel_q8", {28'd0, relQ}, 32'd8);
    checkOutput("rel_tc_clr", {31'd0, relTc}, 32'd0);

    // Load with enable at the top: load wins, no carry, no terminal pulse
    en = 1'b1; dn = 1'b0; ld = 1'b1; din = 4'd15;
    #1;
    checkOutput("ld_cout", {31'd0, wrapCout}, 32'd0);
    applyStimulus();
    ld = 1'b0;
    #1;
    checkOutput("ld_q", {28'd0, wrapQ}, 32'd15);
    checkOutput("ld_tc", {31'd0, wrapTc}, 32'd0);
    checkOutput("ld_cout_next", {31'd0, wrapCout}, 32'd1);
    applyStimulus();
    checkOutput("ld_wrap_q", {28'd0, wrapQ}, 32'd0);
    checkOutput("ld_wrap_tc", {31'd0, wrapTc}, 32'd1);

    // Two-stage cascade, up then down across both boundaries
    en = 1'b0; ld = 1'b1; cDinLo = 4'hE; cDinHi = 4'hF;
    applyStimulus();
    ld = 1'b0; en = 1'b1; dn = 1'b0;
    checkOutput("cas_load", {24'd0, hiQ, loQ}, 32'hFE);
    applyStimulus();
    checkOutput("cas_ff", {24'd0, hiQ, loQ}, 32'hFF);
    checkOutput("cas_hi_cout", {31'd0, hiCout}, 32'd1);
    applyStimulus();
    checkOutput("cas_00", {24'd0, hiQ, loQ}, 32'h00);
    applyStimulus();
    checkOutput("cas_01", {24'd0, hiQ, loQ}, 32'h01);
    dn = 1'b1;
    applyStimulus();
    checkOutput("cas_dn00", {24'd0, hiQ, loQ}, 32'h00);
    checkOutput("cas_dn_cout", {31'd0, hiCout}, 32'd1);
    applyStimulus();
    checkOutput("cas_dnff", {24'd0, hiQ, loQ}, 32'hFF);
    applyStimulus();
    checkOutput("cas_dnfe", {24'd0, hiQ, loQ}, 32'hFE);

    // Reset during a terminal step suppresses carry and pulse
    en = 1'b0; dn = 1'b0; ld = 1'b1; din = 4'd15;
    applyStimulus();
    ld = 1'b0; reset = 1'b1; en = 1'b1;
    #1;
    checkOutput("rst_term_cout", {31'd0, wrapCout}, 32'd0);
    applyStimulus();
    reset = 1'b0; en = 1'b0;
    checkOutput("rst_term_q", {28'd0, wrapQ}, 32'd0);
    checkOutput("rst_term_tc", {31'd0, wrapTc}, 32'd0);

    // Reset mid-count beats a simultaneous load
    ld = 1'b1; din = 4'd7;
    applyStimulus();
    checkOutput("mid_q7", {28'd0, relQ}, 32'd7);
    reset = 1'b1; ld = 1'b1; din = 4'd3; en = 1'b1;
    #1;
    checkOutput("mid_cout", {31'd0, relCout}, 32'd0);
    applyStimulus();
    reset = 1'b0; ld = 1'b0; en = 1'b0;
    checkOutput("mid_q", {28'd0, relQ}, 32'd0);
    checkOutput("mid_rld", {28'd0, relRld}, 32'hA);
    checkOutput("mid_tc", {31'd0, relTc}, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
